// File: rtl/vend_countdown_timer_if.sv
// Handshake and display bundle between the vending FSM and the countdown timer.
//   start       load request pulse (FSM -> timer)
//   load_tens   BCD tens digit of the start value
//   load_ones   BCD ones digit of the start value
//   abort       cancel a running countdown
//   ack         clear the expired indication
//   tens, ones  current BCD digits (timer -> FSM / display)
//   busy        high while counting
//   done        one-cycle expiry pulse
//   expired     expiry level, held until ack or start
interface vend_countdown_timer_if;
  logic       start;
  logic [3:0] load_tens;
  logic [3:0] load_ones;
  logic       abort;
  logic       ack;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       busy;
  logic       done;
  logic       expired;

  modport master (
    output start, load_tens, load_ones, abort, ack,
    input  tens, ones, busy, done, expired
  );

  modport slave (
    input  start, load_tens, load_ones, abort, ack,
    output tens, ones, busy, done, expired
  );
endinterface

// File: rtl/vend_countdown_timer.sv
// Two-digit BCD countdown timer for vending timeouts, stepped by an external
// enable strobe with an optional prescaler.
//   clk    system clock
//   clr_n  asynchronous active-low reset
//   tick   enable strobe; every high cycle counts once
//   bus    slave side of vend_countdown_timer_if (start/load/abort/ack in,
//          digits/busy/done/expired out, all outputs registered)
module vend_countdown_timer #(
  parameter int unsigned TICKS_PER_STEP = 1,
  parameter int unsigned PS_W           = 8
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  tick,
  vend_countdown_timer_if.slave bus
);

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICKS_PER_STEP - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    EXPIRED
  } state_t;

  state_t          state;
  logic [PS_W-1:0] ps;

  // Load digits clamped to 9 so the counter always holds valid BCD.
  logic [3:0] ld_tens_c;
  logic [3:0] ld_ones_c;
  logic       ld_zero_c;
  logic       last_step_c;

  always_comb begin
    ld_tens_c   = (bus.load_tens > 4'd9) ? 4'd9 : bus.load_tens;
    ld_ones_c   = (bus.load_ones > 4'd9) ? 4'd9 : bus.load_ones;
    ld_zero_c   = (ld_tens_c == 4'd0) && (ld_ones_c == 4'd0);
    last_step_c = (bus.tens == 4'd0) && (bus.ones == 4'd1);
  end

  // Control FSM and registered outputs.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state       <= IDLE;
      ps          <= '0;
      bus.tens    <= 4'd0;
      bus.ones    <= 4'd0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.expired <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        IDLE, EXPIRED: begin
          // start outranks ack; a 00 load expires straight away.
          if (bus.start) begin
            bus.tens <= ld_tens_c;
            bus.ones <= ld_ones_c;
            ps       <= '0;
            if (ld_zero_c) begin
              state       <= EXPIRED;
              bus.done    <= 1'b1;
              bus.expired <= 1'b1;
            end else begin
              state       <= RUN;
              bus.busy    <= 1'b1;
              bus.expired <= 1'b0;
            end
          end else if ((state == EXPIRED) && bus.ack) begin
            state       <= IDLE;
            bus.expired <= 1'b0;
          end
        end

        RUN: begin
          if (bus.abort) begin
            state    <= IDLE;
            ps       <= '0;
            bus.tens <= 4'd0;
            bus.ones <= 4'd0;
            bus.busy <= 1'b0;
          end else if (tick) begin
            if (ps != PS_LAST) begin
              ps <= ps + PS_W'(1);
            end else begin
              ps <= '0;
              if (last_step_c) begin
                state       <= EXPIRED;
                bus.ones    <= 4'd0;
                bus.busy    <= 1'b0;
                bus.done    <= 1'b1;
                bus.expired <= 1'b1;
              end else if (bus.ones != 4'd0) begin
                bus.ones <= bus.ones - 4'd1;
              end else begin
                // Borrow from tens; never reached at 00.
                bus.ones <= 4'd9;
                bus.tens <= bus.tens - 4'd1;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_countdown_timer.sv
// Self-checking bench: two timers (TICKS_PER_STEP 1 and 3) driven with the same
// stimulus, compared every cycle against a value-level reference model, plus a
// vector table and hand-written corner sequences.
module tb_vend_countdown_timer;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_EXP  = 2;

  typedef struct {
    int st;
    int val;
    int ps;
    bit busy;
    bit done;
    bit expired;
  } mdl_t;

  typedef struct {
    bit         tk;
    bit         st;
    bit         ab;
    bit         ak;
    logic [3:0] lt;
    logic [3:0] lo;
    int         tens;
    int         ones;
    bit         busy;
    bit         done;
    bit         expd;
  } vec_t;

  logic clk;
  logic clr_n;
  logic tick;

  vend_countdown_timer_if vif1 ();
  vend_countdown_timer_if vif3 ();

  vend_countdown_timer #(.TICKS_PER_STEP(1), .PS_W(8)) dut1 (
    .clk   (clk),
    .clr_n (clr_n),
    .tick  (tick),
    .bus   (vif1)
  );

  vend_countdown_timer #(.TICKS_PER_STEP(3), .PS_W(8)) dut3 (
    .clk   (clk),
    .clr_n (clr_n),
    .tick  (tick),
    .bus   (vif3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  mdl_t m1;
  mdl_t m3;
  vec_t vecs[22];

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r = '{st: M_IDLE, val: 0, ps: 0, busy: 1'b0, done: 1'b0, expired: 1'b0};
    return r;
  endfunction

  // Reference: value kept as a plain integer 0..99.
  function automatic mdl_t mstep(input mdl_t m, input int tps, input bit tk,
                                 input bit st, input bit ab, input bit ak,
                                 input int lt, input int lo);
    mdl_t n;
    int   ld;
    n = m;
    n.done = 1'b0;
    ld = ((lt > 9) ? 9 : lt) * 10 + ((lo > 9) ? 9 : lo);
    if ((m.st == M_IDLE || m.st == M_EXP) && st) begin
      n.val = ld;
      n.ps  = 0;
      if (ld == 0) begin
        n.st = M_EXP; n.done = 1'b1; n.expired = 1'b1; n.busy = 1'b0;
      end else begin
        n.st = M_RUN; n.busy = 1'b1; n.expired = 1'b0;
      end
    end else if (m.st == M_EXP && ak) begin
      n.st = M_IDLE;
      n.expired = 1'b0;
    end else if (m.st == M_RUN) begin
      if (ab) begin
        n.st = M_IDLE; n.val = 0; n.busy = 1'b0; n.ps = 0;
      end else if (tk) begin
        if (m.ps < tps - 1) begin
          n.ps = m.ps + 1;
        end else begin
          n.ps  = 0;
          n.val = m.val - 1;
          if (n.val == 0) begin
            n.st = M_EXP; n.busy = 1'b0; n.done = 1'b1; n.expired = 1'b1;
          end
        end
      end
    end
    return n;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_models();
    check("d1.tens", int'(vif1.tens), m1.val / 10);
    check("d1.ones", int'(vif1.ones), m1.val % 10);
    check("d1.busy", int'(vif1.busy), int'(m1.busy));
    check("d1.done", int'(vif1.done), int'(m1.done));
    check("d1.expired", int'(vif1.expired), int'(m1.expired));
    check("d3.tens", int'(vif3.tens), m3.val / 10);
    check("d3.ones", int'(vif3.ones), m3.val % 10);
    check("d3.busy", int'(vif3.busy), int'(m3.busy));
    check("d3.done", int'(vif3.done), int'(m3.done));
    check("d3.expired", int'(vif3.expired), int'(m3.expired));
  endtask

  task automatic drive(input bit tk, input bit st, input bit ab, input bit ak,
                       input logic [3:0] lt, input logic [3:0] lo);
    tick = tk;
    vif1.start = st; vif1.abort = ab; vif1.ack = ak;
    vif1.load_tens = lt; vif1.load_ones = lo;
    vif3.start = st; vif3.abort = ab; vif3.ack = ak;
    vif3.load_tens = lt; vif3.load_ones = lo;
  endtask

  // One clock: drive after negedge, update models at posedge, check at negedge.
  task automatic cycle(input bit tk, input bit st, input bit ab, input bit ak,
                       input logic [3:0] lt, input logic [3:0] lo);
    drive(tk, st, ab, ak, lt, lo);
    @(posedge clk);
    m1 = mstep(m1, 1, tk, st, ab, ak, int'(lt), int'(lo));
    m3 = mstep(m3, 3, tk, st, ab, ak, int'(lt), int'(lo));
    @(negedge clk);
    check_models();
  endtask

  task automatic quiesce();
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    int done_at;
    bit tk;

    vecs[0]  = '{1, 0, 0, 0, 4'd0,  4'd0,  0, 0, 0, 0, 0};
    vecs[1]  = '{0, 1, 0, 0, 4'd1,  4'd0,  1, 0, 1, 0, 0};
    vecs[2]  = '{1, 0, 0, 0, 4'd0,  4'd0,  0, 9, 1, 0, 0};
    vecs[3]  = '{0, 1, 0, 0, 4'd5,  4'd0,  0, 9, 1, 0, 0};
    vecs[4]  = '{1, 0, 0, 0, 4'd0,  4'd0,  0, 8, 1, 0, 0};
    vecs[5]  = '{1, 0, 1, 0, 4'd0,  4'd0,  0, 0, 0, 0, 0};
    vecs[6]  = '{0, 1, 0, 0, 4'd0,  4'd12, 0, 9, 1, 0, 0};
    vecs[7]  = '{0, 0, 1, 0, 4'd0,  4'd0,  0, 0, 0, 0, 0};
    vecs[8]  = '{0, 1, 0, 0, 4'd0,  4'd1,  0, 1, 1, 0, 0};
    vecs[9]  = '{1, 0, 0, 0, 4'd0,  4'd0,  0, 0, 0, 1, 1};
    vecs[10] = '{0, 0, 0, 0, 4'd0,  4'd0,  0, 0, 0, 0, 1};
    vecs[11] = '{1, 0, 0, 0, 4'd0,  4'd0,  0, 0, 0, 0, 1};
    vecs[12] = '{0, 1, 0, 1, 4'd0,  4'd2,  0, 2, 1, 0, 0};
    vecs[13] = '{1, 0, 0, 0, 4'd0,  4'd0,  0, 1, 1, 0, 0};
    vecs[14] = '{1, 0, 1, 0, 4'd0,  4'd0,  0, 0, 0, 0, 0};
    vecs[15] = '{0, 1, 0, 0, 4'd0,  4'd0,  0, 0, 0, 1, 1};
    vecs[16] = '{0, 0, 0, 0, 4'd0,  4'd0,  0, 0, 0, 0, 1};
    vecs[17] = '{0, 0, 0, 1, 4'd0,  4'd0,  0, 0, 0, 0, 0};
    vecs[18] = '{0, 1, 0, 0, 4'd9,  4'd9,  9, 9, 1, 0, 0};
    vecs[19] = '{1, 0, 0, 0, 4'd0,  4'd0,  9, 8, 1, 0, 0};
    vecs[20] = '{0, 1, 0, 1, 4'd15, 4'd15, 9, 8, 1, 0, 0};
    vecs[21] = '{0, 0, 1, 0, 4'd0,  4'd0,  0, 0, 0, 0, 0};

    clr_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    m1 = mdl_reset();
    m3 = mdl_reset();
    repeat (2) @(negedge clk);
    check_models();
    clr_n = 1'b1;

    // Vector table against the TICKS_PER_STEP=1 instance.
    foreach (vecs[i]) begin
      cycle(vecs[i].tk, vecs[i].st, vecs[i].ab, vecs[i].ak, vecs[i].lt, vecs[i].lo);
      check($sformatf("vec%0d.tens", i), int'(vif1.tens), vecs[i].tens);
      check($sformatf("vec%0d.ones", i), int'(vif1.ones), vecs[i].ones);
      check($sformatf("vec%0d.busy", i), int'(vif1.busy), int'(vecs[i].busy));
      check($sformatf("vec%0d.done", i), int'(vif1.done), int'(vecs[i].done));
      check($sformatf("vec%0d.expired", i), int'(vif1.expired), int'(vecs[i].expd));
    end

    // 03 with a tick every 5 clocks.
    quiesce();
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd3);
    busy_cnt = int'(vif1.busy);
    done_cnt = 0;
    done_at  = -1;
    for (int i = 1; i <= 20; i++) begin
      cycle((i % 5) == 0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
      busy_cnt += int'(vif1.busy);
      if (vif1.done) begin
        done_cnt++;
        done_at = i;
      end
    end
    check("t03.busy_cycles", busy_cnt, 15);
    check("t03.done_count", done_cnt, 1);
    check("t03.done_cycle", done_at, 15);
    check("t03.expired_held", int'(vif1.expired), 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
    check("t03.expired_after_ack", int'(vif1.expired), 0);

    // 10 -> 09 borrow and expiry on the 10th tick.
    quiesce();
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0);
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
      if (i == 1) begin
        check("t10.tens_after1", int'(vif1.tens), 0);
        check("t10.ones_after1", int'(vif1.ones), 9);
      end
    end
    check("t10.done", int'(vif1.done), 1);
    check("t10.busy", int'(vif1.busy), 0);

    // Prescaled instance: idle ticks ignored, steps on the 3rd and 6th tick.
    quiesce();
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    check("p3.idle_ones", int'(vif3.ones), 0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd2);
    for (int j = 1; j <= 6; j++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
      if (j == 2) check("p3.ones_tick2", int'(vif3.ones), 2);
      if (j == 3) check("p3.ones_tick3", int'(vif3.ones), 1);
      if (j == 5) check("p3.done_tick5", int'(vif3.done), 0);
    end
    check("p3.done_tick6", int'(vif3.done), 1);
    check("p3.expired_tick6", int'(vif3.expired), 1);

    // Asynchronous reset mid-count.
    quiesce();
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd5);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    #2 clr_n = 1'b0;
    #1;
    check("rst.d1.busy", int'(vif1.busy), 0);
    check("rst.d1.ones", int'(vif1.ones), 0);
    check("rst.d3.busy", int'(vif3.busy), 0);
    check("rst.d3.ones", int'(vif3.ones), 0);
    check("rst.d1.done", int'(vif1.done), 0);
    m1 = mdl_reset();
    m3 = mdl_reset();
    @(posedge clk);
    @(negedge clk);
    check_models();
    clr_n = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);

    // Randomized traffic against the reference model.
    for (int k = 0; k < 4000; k++) begin
      tk = ($urandom_range(0, 99) < 60);
      cycle(tk,
            ($urandom_range(0, 99) < 6),
            ($urandom_range(0, 199) < 3),
            ($urandom_range(0, 99) < 8),
            4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
